// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, FSM states
// and the datapath mux/ALU select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsRAlu = 4'd0,
    ClsIAlu = 4'd1,
    ClsLw   = 4'd2,
    ClsSw   = 4'd3,
    ClsBeq  = 4'd4,
    ClsJ    = 4'd5,
    ClsJal  = 4'd6,
    ClsJr   = 4'd7,
    ClsIll  = 4'd8
  } insn_class_e;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [1:0] REGDST_RD = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;

endpackage

// File: rtl/mips_insn_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU function,
// immediate extension and operand select.
module mips_insn_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_class,
  output logic [2:0] o_aluop,
  output logic [1:0] o_extop,
  output logic       o_alusrc,
  output logic       o_legal
);

  always_comb begin
    o_class  = ClsIll;
    o_aluop  = ALU_ADD;
    o_extop  = EXT_ZERO;
    o_alusrc = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_class = ClsRAlu;
          FN_SUBU: begin o_class = ClsRAlu; o_aluop = ALU_SUB; end
          FN_SLT:  begin o_class = ClsRAlu; o_aluop = ALU_SLT; end
          FN_AND:  begin o_class = ClsRAlu; o_aluop = ALU_AND; end
          FN_JR:   o_class = ClsJr;
          default: o_class = ClsIll;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin o_class = ClsIAlu; o_extop = EXT_SIGN; o_alusrc = 1'b1; end
      OP_ORI:  begin o_class = ClsIAlu; o_aluop = ALU_OR; o_alusrc = 1'b1; end
      OP_LUI:  begin o_class = ClsIAlu; o_extop = EXT_LUI; o_alusrc = 1'b1; end
      OP_LW:   begin o_class = ClsLw; o_extop = EXT_SIGN; o_alusrc = 1'b1; end
      OP_SW:   begin o_class = ClsSw; o_extop = EXT_SIGN; o_alusrc = 1'b1; end
      OP_BEQ:  begin o_class = ClsBeq; o_aluop = ALU_SUB; end
      OP_J:    o_class = ClsJ;
      OP_JAL:  o_class = ClsJal;
      default: o_class = ClsIll;
    endcase
    o_legal = (o_class != ClsIll);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait states,
// access timeout and illegal-opcode trap, plus a retired-instruction counter.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_EN = 1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ALUOP_W     = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic               i_zero,
  input  logic               i_imem_ready,
  input  logic               i_dmem_ready,
  output logic               o_imem_req,
  output logic               o_dmem_req,
  output logic               o_memwe,
  output logic               o_irwe,
  output logic               o_mdrwe,
  output logic               o_pcwe,
  output logic [1:0]         o_pcsrc,
  output logic               o_regwe,
  output logic [1:0]         o_regdst,
  output logic [1:0]         o_memtoreg,
  output logic               o_alusrc,
  output logic [1:0]         o_extop,
  output logic [ALUOP_W-1:0] o_aluop,
  output logic               o_illegal,
  output logic               o_instr_done,
  output logic [CNT_W-1:0]   o_retired
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e            r_state, w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_retired;

  logic       w_imem_rdy, w_dmem_rdy, w_timeout, w_done;
  logic [3:0] w_class;
  logic [2:0] w_aluop;
  logic [1:0] w_extop;
  logic       w_alusrc, w_legal;

  mips_insn_decode u_decode (
    .i_opcode (i_opcode),
    .i_funct  (i_funct),
    .o_class  (w_class),
    .o_aluop  (w_aluop),
    .o_extop  (w_extop),
    .o_alusrc (w_alusrc),
    .o_legal  (w_legal)
  );

  assign w_imem_rdy = (MEM_WAIT_EN == 0) || i_imem_ready;
  assign w_dmem_rdy = (MEM_WAIT_EN == 0) || i_dmem_ready;
  // Trap only once the full budget of wait cycles has elapsed; ready on that cycle still wins.
  assign w_timeout  = (MEM_TIMEOUT != 0) && (r_wait == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    w_next       = r_state;
    o_imem_req   = 1'b0;
    o_dmem_req   = 1'b0;
    o_memwe      = 1'b0;
    o_irwe       = 1'b0;
    o_mdrwe      = 1'b0;
    o_pcwe       = 1'b0;
    o_pcsrc      = PCSRC_SEQ;
    o_regwe      = 1'b0;
    o_regdst     = REGDST_RD;
    o_memtoreg   = M2R_ALU;
    o_alusrc     = 1'b0;
    o_extop      = EXT_ZERO;
    o_aluop      = '0;
    case (r_state)
      StFetch: begin
        o_imem_req = 1'b1;
        if (w_imem_rdy) begin
          o_irwe = 1'b1;
          o_pcwe = 1'b1;
          w_next = StDecode;
        end else if (w_timeout) begin
          w_next = StTrap;
        end
      end
      StDecode: begin
        if (!w_legal) begin
          w_next = StTrap;
        end else if (w_class == ClsJ) begin
          o_pcwe  = 1'b1;
          o_pcsrc = PCSRC_JMP;
          w_next  = StFetch;
        end else if (w_class == ClsJal) begin
          o_regwe    = 1'b1;
          o_regdst   = REGDST_RA;
          o_memtoreg = M2R_PC;
          o_pcwe     = 1'b1;
          o_pcsrc    = PCSRC_JMP;
          w_next     = StFetch;
        end else if (w_class == ClsJr) begin
          o_pcwe  = 1'b1;
          o_pcsrc = PCSRC_JR;
          w_next  = StFetch;
        end else begin
          w_next = StExec;
        end
      end
      StExec: begin
        o_alusrc = w_alusrc;
        o_extop  = w_extop;
        o_aluop  = ALUOP_W'(w_aluop);
        if (w_class == ClsLw || w_class == ClsSw) begin
          w_next = StMem;
        end else if (w_class == ClsBeq) begin
          o_pcwe  = i_zero;
          o_pcsrc = i_zero ? PCSRC_BR : PCSRC_SEQ;
          w_next  = StFetch;
        end else begin
          w_next = StWb;
        end
      end
      StMem: begin
        o_dmem_req = 1'b1;
        o_memwe    = (w_class == ClsSw);
        if (w_dmem_rdy) begin
          if (w_class == ClsSw) begin
            w_next = StFetch;
          end else begin
            o_mdrwe = 1'b1;
            w_next  = StWb;
          end
        end else if (w_timeout) begin
          w_next = StTrap;
        end
      end
      StWb: begin
        o_regwe    = 1'b1;
        o_regdst   = (w_class == ClsRAlu) ? REGDST_RD : REGDST_RT;
        o_memtoreg = (w_class == ClsLw) ? M2R_MDR : M2R_ALU;
        w_next     = StFetch;
      end
      StTrap:  w_next = StTrap;
      default: w_next = StTrap;
    endcase
    w_done       = (w_next == StFetch) && (r_state != StFetch);
    o_instr_done = w_done;
    // Reset is asynchronous to the outputs as well: requests drop the moment it asserts.
    if (i_rst) begin
      o_imem_req   = 1'b0;
      o_dmem_req   = 1'b0;
      o_memwe      = 1'b0;
      o_irwe       = 1'b0;
      o_mdrwe      = 1'b0;
      o_pcwe       = 1'b0;
      o_pcsrc      = PCSRC_SEQ;
      o_regwe      = 1'b0;
      o_regdst     = REGDST_RD;
      o_memtoreg   = M2R_ALU;
      o_alusrc     = 1'b0;
      o_extop      = EXT_ZERO;
      o_aluop      = '0;
      o_instr_done = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StFetch;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == StFetch && !w_imem_rdy) || (r_state == StMem && !w_dmem_rdy)) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_next == StTrap) r_illegal <= 1'b1;
      if (w_done) r_retired <= r_retired + 1'b1;
    end
  end

  assign o_illegal = r_illegal;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each issued instruction pushes its expected control summary; a monitor
// accumulates DUT activity per instruction and compares on retire or trap.
module tb_multicycle_controller;

  localparam int TMO   = 16;
  localparam int CNT_W = 4;
  localparam int STUCK = 100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, memwe, irwe, mdrwe, pcwe, regwe, alusrc, illegal, instr_done;
  logic [1:0] pcsrc, regdst, memtoreg, extop;
  logic [2:0] aluop;
  logic [CNT_W-1:0] retired;
  logic       any_out;

  always #5 clk = ~clk;

  multicycle_controller #(
    .MEM_WAIT_EN (1),
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CNT_W),
    .ALUOP_W     (3)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opcode     (opcode),
    .i_funct      (funct),
    .i_zero       (zero),
    .i_imem_ready (imem_ready),
    .i_dmem_ready (dmem_ready),
    .o_imem_req   (imem_req),
    .o_dmem_req   (dmem_req),
    .o_memwe      (memwe),
    .o_irwe       (irwe),
    .o_mdrwe      (mdrwe),
    .o_pcwe       (pcwe),
    .o_pcsrc      (pcsrc),
    .o_regwe      (regwe),
    .o_regdst     (regdst),
    .o_memtoreg   (memtoreg),
    .o_alusrc     (alusrc),
    .o_extop      (extop),
    .o_aluop      (aluop),
    .o_illegal    (illegal),
    .o_instr_done (instr_done),
    .o_retired    (retired)
  );

  assign any_out = |{imem_req, dmem_req, memwe, irwe, mdrwe, pcwe, pcsrc, regwe, regdst,
                     memtoreg, alusrc, extop, aluop, illegal, instr_done, retired};

  // Per-instruction activity summary; "or" fields collect the select values seen while enabled.
  typedef struct {
    int kind;  // 0 retired, 1 trapped
    int cyc; int ireq; int irwe; int pcwe; int pcsrc;
    int regwe; int regdst; int m2r; int dreq; int memwe; int mdr;
    int aluop; int extop; int alusrc; int ret;
  } rec_t;

  rec_t exp_q[$];
  int   n_chk = 0, n_err = 0;
  int   wi = 0, wd = 0;
  int   model_ret = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle cost and control activity from the instruction's phase list.
  function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                 input int iw, input int dw, input int ret);
    rec_t r;
    r = '{default: 0};
    r.ret = ret;
    r.cyc = 2 + iw; r.ireq = 1 + iw; r.irwe = 1; r.pcwe = 1;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100001: begin r.cyc += 2; r.regwe = 1; r.aluop = 0; end
          6'b100011: begin r.cyc += 2; r.regwe = 1; r.aluop = 1; end
          6'b101010: begin r.cyc += 2; r.regwe = 1; r.aluop = 3; end
          6'b100100: begin r.cyc += 2; r.regwe = 1; r.aluop = 4; end
          6'b001000: begin r.pcwe = 2; r.pcsrc = 3; end
          default:   r.kind = 1;
        endcase
      end
      6'b001000, 6'b001001: begin
        r.cyc += 2; r.regwe = 1; r.regdst = 1; r.extop = 1; r.alusrc = 1;
      end
      6'b001101: begin r.cyc += 2; r.regwe = 1; r.regdst = 1; r.aluop = 2; r.alusrc = 1; end
      6'b001111: begin r.cyc += 2; r.regwe = 1; r.regdst = 1; r.extop = 2; r.alusrc = 1; end
      6'b100011: begin
        r.cyc += 3 + dw; r.dreq = 1 + dw; r.mdr = 1;
        r.regwe = 1; r.regdst = 1; r.m2r = 1; r.extop = 1; r.alusrc = 1;
      end
      6'b101011: begin
        r.cyc += 2 + dw; r.dreq = 1 + dw; r.memwe = 1 + dw; r.extop = 1; r.alusrc = 1;
      end
      6'b000100: begin
        r.cyc += 1; r.aluop = 1;
        if (z) begin r.pcwe = 2; r.pcsrc = 1; end
      end
      6'b000010: begin r.pcwe = 2; r.pcsrc = 2; end
      6'b000011: begin r.pcwe = 2; r.pcsrc = 2; r.regwe = 1; r.regdst = 2; r.m2r = 2; end
      default:   r.kind = 1;
    endcase
    return r;
  endfunction

  task automatic compare(input rec_t a);
    rec_t e;
    if (exp_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard_empty: got record kind %0d, required none", a.kind);
      return;
    end
    e = exp_q.pop_front();
    chk("kind", a.kind, e.kind);       chk("cycles", a.cyc, e.cyc);
    chk("imem_req_cyc", a.ireq, e.ireq); chk("irwe_cyc", a.irwe, e.irwe);
    chk("pcwe_cyc", a.pcwe, e.pcwe);   chk("pcsrc", a.pcsrc, e.pcsrc);
    chk("regwe_cyc", a.regwe, e.regwe); chk("regdst", a.regdst, e.regdst);
    chk("memtoreg", a.m2r, e.m2r);     chk("dmem_req_cyc", a.dreq, e.dreq);
    chk("memwe_cyc", a.memwe, e.memwe); chk("mdrwe_cyc", a.mdr, e.mdr);
    chk("aluop", a.aluop, e.aluop);    chk("extop", a.extop, e.extop);
    chk("alusrc", a.alusrc, e.alusrc); chk("retired", a.ret, e.ret);
  endtask

  // Memory models: ready after the configured number of wait cycles of a held request.
  initial begin
    int icnt = 0, dcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin imem_ready = (icnt == wi); icnt++; end
      else begin imem_ready = 1'b0; icnt = 0; end
      if (dmem_req) begin dmem_ready = (dcnt == wd); dcnt++; end
      else begin dmem_ready = 1'b0; dcnt = 0; end
    end
  end

  // Monitor
  initial begin
    rec_t acc;
    bit   trap_seen = 1'b0;
    acc = '{default: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = '{default: 0};
        trap_seen = 1'b0;
      end else if (illegal) begin
        if (!trap_seen) begin
          trap_seen = 1'b1;
          acc.kind = 1; acc.ret = int'(retired);
          compare(acc);
          acc = '{default: 0};
        end
      end else begin
        acc.cyc++;
        acc.ireq += int'(imem_req); acc.irwe += int'(irwe); acc.pcwe += int'(pcwe);
        acc.regwe += int'(regwe); acc.dreq += int'(dmem_req);
        acc.memwe += int'(memwe); acc.mdr += int'(mdrwe);
        if (pcwe) acc.pcsrc = acc.pcsrc | int'(pcsrc);
        if (regwe) begin
          acc.regdst = acc.regdst | int'(regdst);
          acc.m2r    = acc.m2r | int'(memtoreg);
        end
        acc.aluop  = acc.aluop | int'(aluop);
        acc.extop  = acc.extop | int'(extop);
        acc.alusrc = acc.alusrc | int'(alusrc);
        if (instr_done) begin
          acc.kind = 0; acc.ret = int'(retired);
          compare(acc);
          acc = '{default: 0};
        end
      end
    end
  end

  // Called just after a rising edge in the first FETCH cycle of the instruction.
  task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input bit z,
                          input int iw, input int dw, input bit stuck_i, input bit stuck_d);
    rec_t r;
    r = model(op, fn, z, iw, dw, model_ret);
    if (stuck_i) begin
      r = '{default: 0};
      r.kind = 1; r.cyc = TMO + 1; r.ireq = TMO + 1; r.ret = model_ret;
    end
    if (stuck_d) r.kind = 1;
    exp_q.push_back(r);
    opcode = op; funct = fn; zero = z;
    wi = stuck_i ? STUCK : iw;
    wd = stuck_d ? STUCK : dw;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (r.kind == 0 && instr_done) break;
      if (r.kind == 1 && illegal) break;
      if (c == 199) begin
        n_chk++; n_err++;
        $display("FAIL insn_timeout: op %b funct %b got no retire/trap, required one", op, fn);
      end
    end
    if (r.kind == 0) model_ret = (model_ret + 1) % (1 << CNT_W);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_tail();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("trap_imem_req", int'(imem_req), 0);
      chk("trap_illegal_sticky", int'(illegal), 1);
      chk("trap_instr_done", int'(instr_done), 0);
    end
    chk("trap_retired_hold", int'(retired), model_ret);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", int'(any_out), 0);
    model_ret = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [11:0] legal_tab [14] = '{
    {6'b000000, 6'b100001}, {6'b000000, 6'b100011}, {6'b000000, 6'b101010},
    {6'b000000, 6'b100100}, {6'b000000, 6'b001000}, {6'b001000, 6'b000000},
    {6'b001001, 6'b000000}, {6'b001101, 6'b000000}, {6'b001111, 6'b000000},
    {6'b100011, 6'b000000}, {6'b101011, 6'b000000}, {6'b000100, 6'b000000},
    {6'b000010, 6'b000000}, {6'b000011, 6'b000000}
  };

  initial begin
    logic [11:0] ent;
    int k, iw;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", int'(any_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_insn(6'b000000, 6'b100001, 1'b0, 0, 0, 1'b0, 1'b0);  // addu
    run_insn(6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0, 1'b0);  // lw, 3 dmem waits
    run_insn(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0, 1'b0);  // beq taken
    run_insn(6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);  // beq not taken
    run_insn(6'b000011, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);  // jal
    run_insn(6'b000000, 6'b101010, 1'b0, TMO, 0, 1'b0, 1'b0);  // ready exactly at the limit
    run_insn(6'b101011, 6'b000000, 1'b0, 1, TMO, 1'b0, 1'b0);  // sw, dmem ready at limit

    for (int n = 0; n < 40; n++) begin
      k   = $urandom_range(0, 13);
      ent = legal_tab[k];
      iw  = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
      run_insn(ent[11:6], ent[5:0], 1'($urandom_range(0, 1)), iw, $urandom_range(0, 4),
               1'b0, 1'b0);
    end
    chk("retired_after_random", int'(retired), model_ret);

    run_insn(6'b111111, 6'b000000, 1'b0, 1, 0, 1'b0, 1'b0);  // illegal opcode
    trap_tail();
    run_insn(6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);  // illegal R funct
    trap_tail();
    run_insn(6'b000000, 6'b100001, 1'b0, 0, 0, 1'b1, 1'b0);  // imem never ready
    trap_tail();
    run_insn(6'b101011, 6'b000000, 1'b0, 2, TMO, 1'b0, 1'b1);  // dmem never ready
    trap_tail();
    run_insn(6'b001101, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);  // recovers after reset

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("retired_final", int'(retired), model_ret);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
